bf_fetch_unit: RTL

- Instruction fetch stage directly upstream of the BF processor core.
- Reads ASCII program bytes from external program memory over a req/ack handshake.
- Decodes the eight BF characters to opcodes and drops comment bytes.
- Buffers opcodes in a small prefetch FIFO, and supports PC redirects from the core's loop logic, which flush the buffer.

---
 rtl/bf_pkg.sv | 59 +++++
 rtl/bf_op_fifo.sv | 66 ++++++
 rtl/bf_fetch_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/bf_pkg.sv
// Shared opcode, character and FSM definitions for the BF fetch path.
package bf_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_INC   = 4'd0,
      OP_DEC   = 4'd1,
      OP_RIGHT = 4'd2,
      OP_LEFT  = 4'd3,
      OP_LOOP  = 4'd4,
      OP_END   = 4'd5,
      OP_OUT   = 4'd6,
      OP_IN    = 4'd7,
      OP_HALT  = 4'd8
   } op_e;

   localparam logic [7:0] CH_INC   = 8'h2B;
   localparam logic [7:0] CH_DEC   = 8'h2D;
   localparam logic [7:0] CH_RIGHT = 8'h3E;
   localparam logic [7:0] CH_LEFT  = 8'h3C;
   localparam logic [7:0] CH_LOOP  = 8'h5B;
   localparam logic [7:0] CH_END   = 8'h5D;
   localparam logic [7:0] CH_OUT   = 8'h2E;
   localparam logic [7:0] CH_IN    = 8'h2C;
   localparam logic [7:0] CH_NUL   = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_HALT
   } fetch_state_e;

   typedef struct packed {
      logic vld;
      op_e  op;
   } dec_t;

   // Anything outside the eight BF characters and NUL is a comment (vld=0).
   function automatic dec_t decode(input logic [7:0] b);
      dec_t d;
      d.vld = 1'b1;
      d.op  = OP_INC;
      case (b)
         CH_INC:   d.op = OP_INC;
         CH_DEC:   d.op = OP_DEC;
         CH_RIGHT: d.op = OP_RIGHT;
         CH_LEFT:  d.op = OP_LEFT;
         CH_LOOP:  d.op = OP_LOOP;
         CH_END:   d.op = OP_END;
         CH_OUT:   d.op = OP_OUT;
         CH_IN:    d.op = OP_IN;
         CH_NUL:   d.op = OP_HALT;
         default:  d.vld = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/bf_op_fifo.sv
// Show-ahead opcode FIFO with flush; head stays on the last shown entry when empty.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is dropped when full, pop ignored when empty; flush wins over both.
module bf_op_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head_dat,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] head_q;
   logic             wr_en;
   logic             rd_en;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign wr_en    = push && !full;
   assign rd_en    = pop && !empty;
   assign head_dat = empty ? head_q : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst_n && wr_en && !flush) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head_q <= '0;
      end else begin
         head_q <= head_dat;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: rtl/bf_fetch_unit.sv
// BF instruction fetch: reads program bytes, decodes, drops comments, queues opcodes.
// Latency: byte acked in cycle N is at the FIFO head in N+1; one byte per 2 cycles max.
// Backpressure: no new request while the FIFO is full; redirect flushes and restarts.
module bf_fetch_unit
   import bf_pkg::*;
#(
   parameter int PC_W       = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic              mem_req,
   output logic [PC_W-1:0]   mem_addr,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [OP_W-1:0]   instr_op,
   output logic [PC_W-1:0]   instr_pc,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              halted
);

   localparam int ENT_W = OP_W + PC_W;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e     state;
   logic [PC_W-1:0]  fetch_pc;
   dec_t             dec;
   logic             push_vld;
   logic             pop_vld;
   logic [ENT_W-1:0] push_dat;
   logic [ENT_W-1:0] head_dat;
   logic [CNT_W-1:0] fifo_cnt;
   logic             fifo_empty;
   logic             fifo_full;

   assign dec         = decode(mem_rdata);
   assign push_vld    = (state == ST_REQ) && mem_ack && dec.vld && !redirect_valid && !fifo_full;
   assign pop_vld     = instr_valid && instr_ready;
   assign push_dat    = {dec.op, fetch_pc};
   assign instr_valid = !fifo_empty;
   assign instr_op    = head_dat[ENT_W-1:PC_W];
   assign instr_pc    = head_dat[PC_W-1:0];

   bf_op_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push_vld),
      .push_dat (push_dat),
      .pop      (pop_vld),
      .flush    (redirect_valid),
      .head_dat (head_dat),
      .count    (fifo_cnt),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         fetch_pc <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         halted   <= 1'b0;
      end else if (redirect_valid) begin
         // Redirect abandons any outstanding read; a same-cycle ack is dropped.
         state    <= ST_IDLE;
         fetch_pc <= redirect_pc;
         mem_req  <= 1'b0;
         halted   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (en && (fifo_cnt < CNT_W'(FIFO_DEPTH))) begin
                  state    <= ST_REQ;
                  mem_req  <= 1'b1;
                  mem_addr <= fetch_pc;
               end
            end
            ST_REQ: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (dec.vld && dec.op == OP_HALT) begin
                     state  <= ST_HALT;
                     halted <= 1'b1;
                  end else begin
                     state    <= ST_IDLE;
                     fetch_pc <= fetch_pc + PC_W'(1);
                  end
               end
            end
            default: begin
               state   <= ST_HALT;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
